// File: rtl/regread_exe_latch_pkg.sv
// Shared types for the register-read / execute boundary: the bypass packet
// broadcast by every issue lane and the widths it is built from.
package regread_exe_latch_pkg;

    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int SIZE_DATA         = 64;
    localparam int ISSUE_WIDTH       = 4;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypassPkt;

endpackage

// File: rtl/regread_exe_latch_operand_snoop.sv
// Combinational bypass snoop for one held source operand; lane priority
// matches the register-read bypass mux (highest matching lane wins).
module regread_exe_latch_operand_snoop
    import regread_exe_latch_pkg::*;
(
    input  logic [SIZE_PHYSICAL_LOG-1:0] tag,
    input  logic                         src_valid,
    input  logic [SIZE_DATA-1:0]         held_data,
    input  bypassPkt                     bypass_packet [0:ISSUE_WIDTH-1],
    output logic [SIZE_DATA-1:0]         next_data
);

    always_comb begin
        next_data = held_data;
        if (src_valid) begin
            // Later lanes overwrite earlier ones, so the highest index wins.
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (bypass_packet[i].valid && (bypass_packet[i].tag == tag)) begin
                    next_data = bypass_packet[i].data;
                end
            end
        end
    end

endmodule

// File: rtl/regread_exe_latch.sv
// Register-read to execute pipeline latch with valid/ready handshake, flush,
// bypass snooping of held operands and a saturating stall counter.
module regread_exe_latch
    import regread_exe_latch_pkg::*;
#(
    parameter int PAYLOAD_WIDTH   = 96,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [PAYLOAD_WIDTH-1:0]     payload_i,
    input  logic                         src1Valid_i,
    input  logic                         src2Valid_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] phySrc1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0] phySrc2_i,
    input  logic [SIZE_DATA-1:0]         src1Data_i,
    input  logic [SIZE_DATA-1:0]         src2Data_i,
    input  bypassPkt                     bypassPacket_i [0:ISSUE_WIDTH-1],
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [PAYLOAD_WIDTH-1:0]     payload_o,
    output logic [SIZE_DATA-1:0]         src1Data_o,
    output logic [SIZE_DATA-1:0]         src2Data_o,
    output logic [STALL_CNT_WIDTH-1:0]   stallCycles_o
);

    // Handshake: a transfer happens on either side when valid && ready on that
    // side at the rising edge; ready_o never looks at valid_i.
    logic                         valid_q, valid_d;
    logic [PAYLOAD_WIDTH-1:0]     payload_q, payload_d;
    logic [SIZE_PHYSICAL_LOG-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
    logic                         src1_valid_q, src1_valid_d;
    logic                         src2_valid_q, src2_valid_d;
    logic [SIZE_DATA-1:0]         data1_q, data1_d, data2_q, data2_d;
    logic [SIZE_DATA-1:0]         snoop1_data, snoop2_data;
    logic [STALL_CNT_WIDTH-1:0]   stall_q, stall_d;
    logic                         load, drain, hold;

    assign ready_o = !valid_q || ready_i;
    assign load    = valid_i && ready_o && !flush_i;
    assign drain   = valid_q && ready_i;
    assign hold    = valid_q && !ready_i && !flush_i;

    regread_exe_latch_operand_snoop u_snoop1 (
        .tag           (tag1_q),
        .src_valid     (src1_valid_q),
        .held_data     (data1_q),
        .bypass_packet (bypassPacket_i),
        .next_data     (snoop1_data)
    );

    regread_exe_latch_operand_snoop u_snoop2 (
        .tag           (tag2_q),
        .src_valid     (src2_valid_q),
        .held_data     (data2_q),
        .bypass_packet (bypassPacket_i),
        .next_data     (snoop2_data)
    );

    always_comb begin
        valid_d      = valid_q;
        payload_d    = payload_q;
        tag1_d       = tag1_q;
        tag2_d       = tag2_q;
        src1_valid_d = src1_valid_q;
        src2_valid_d = src2_valid_q;
        data1_d      = data1_q;
        data2_d      = data2_q;
        stall_d      = stall_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            // Incoming operands are already bypass-resolved; no snoop here.
            valid_d      = 1'b1;
            payload_d    = payload_i;
            tag1_d       = phySrc1_i;
            tag2_d       = phySrc2_i;
            src1_valid_d = src1Valid_i;
            src2_valid_d = src2Valid_i;
            data1_d      = src1Data_i;
            data2_d      = src2Data_i;
        end else if (drain) begin
            valid_d = 1'b0;
        end else if (hold) begin
            data1_d = snoop1_data;
            data2_d = snoop2_data;
        end

        if (hold && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            payload_q    <= '0;
            tag1_q       <= '0;
            tag2_q       <= '0;
            src1_valid_q <= 1'b0;
            src2_valid_q <= 1'b0;
            data1_q      <= '0;
            data2_q      <= '0;
            stall_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            payload_q    <= payload_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            src1_valid_q <= src1_valid_d;
            src2_valid_q <= src2_valid_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            stall_q      <= stall_d;
        end
    end

    assign valid_o       = valid_q;
    assign payload_o     = payload_q;
    assign src1Data_o    = data1_q;
    assign src2Data_o    = data2_q;
    assign stallCycles_o = stall_q;

endmodule

// File: tb/tb_regread_exe_latch.sv
// Self-checking bench for regread_exe_latch: handshake vector table, streaming
// scoreboard, reset, bypass snoop and stall counter saturation sequences.
module tb_regread_exe_latch;
    import regread_exe_latch_pkg::*;

    localparam int PW = 96;
    localparam int SW = 4;

    logic                         clk;
    logic                         reset;
    logic                         flush_i;
    logic                         valid_i;
    logic                         ready_o;
    logic [PW-1:0]                payload_i;
    logic                         src1Valid_i;
    logic                         src2Valid_i;
    logic [SIZE_PHYSICAL_LOG-1:0] phySrc1_i;
    logic [SIZE_PHYSICAL_LOG-1:0] phySrc2_i;
    logic [SIZE_DATA-1:0]         src1Data_i;
    logic [SIZE_DATA-1:0]         src2Data_i;
    bypassPkt                     bypass [0:ISSUE_WIDTH-1];
    logic                         valid_o;
    logic                         ready_i;
    logic [PW-1:0]                payload_o;
    logic [SIZE_DATA-1:0]         src1Data_o;
    logic [SIZE_DATA-1:0]         src2Data_o;
    logic [SW-1:0]                stallCycles_o;

    int checks;
    int errors;
    logic [PW-1:0] exp_q[$];

    regread_exe_latch #(
        .PAYLOAD_WIDTH   (PW),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .payload_i      (payload_i),
        .src1Valid_i    (src1Valid_i),
        .src2Valid_i    (src2Valid_i),
        .phySrc1_i      (phySrc1_i),
        .phySrc2_i      (phySrc2_i),
        .src1Data_i     (src1Data_i),
        .src2Data_i     (src2Data_i),
        .bypassPacket_i (bypass),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .payload_o      (payload_o),
        .src1Data_o     (src1Data_o),
        .src2Data_o     (src2Data_o),
        .stallCycles_o  (stallCycles_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vi;
        logic          ri;
        logic          fl;
        logic [PW-1:0] pl;
        logic          exp_ready;
        logic          exp_valid;
        logic          chk_pl;
        logic [PW-1:0] exp_pl;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            bypass[i].valid = 1'b0;
            bypass[i].tag   = '0;
            bypass[i].data  = '0;
        end
    endtask

    task automatic drive_idle();
        valid_i     = 1'b0;
        flush_i     = 1'b0;
        payload_i   = '0;
        src1Valid_i = 1'b0;
        src2Valid_i = 1'b0;
        phySrc1_i   = '0;
        phySrc2_i   = '0;
        src1Data_i  = '0;
        src2Data_i  = '0;
        clear_bypass();
    endtask

    initial begin
        logic [PW-1:0] exp_pl;
        checks = 0;
        errors = 0;

        // Handshake table, starting from an empty latch.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 96'hA1, 1'b1, 1'b1, 1'b1, 96'hA1}; // load
        vecs[1] = '{1'b1, 1'b0, 1'b0, 96'hA2, 1'b0, 1'b1, 1'b1, 96'hA1}; // held, A2 refused
        vecs[2] = '{1'b1, 1'b1, 1'b0, 96'hA3, 1'b1, 1'b1, 1'b1, 96'hA3}; // drain + load
        vecs[3] = '{1'b0, 1'b1, 1'b0, 96'hA4, 1'b1, 1'b0, 1'b0, 96'h0};  // drain
        vecs[4] = '{1'b1, 1'b0, 1'b1, 96'hA5, 1'b1, 1'b0, 1'b0, 96'h0};  // flush blocks load
        vecs[5] = '{1'b1, 1'b0, 1'b0, 96'hA6, 1'b1, 1'b1, 1'b1, 96'hA6}; // load
        vecs[6] = '{1'b1, 1'b0, 1'b1, 96'hA7, 1'b0, 1'b0, 1'b1, 96'hA6}; // flush over held + incoming
        vecs[7] = '{1'b0, 1'b0, 1'b0, 96'hA8, 1'b1, 1'b0, 1'b0, 96'h0};  // idle

        reset   = 1'b0;
        ready_i = 1'b0;
        drive_idle();
        repeat (2) step();
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_stall", 128'(stallCycles_o), 128'(0));
        chk("rst_payload", 128'(payload_o), 128'(0));
        chk("rst_src1", 128'(src1Data_o), 128'(0));
        chk("rst_src2", 128'(src2Data_o), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst_ready", 128'(ready_o), 128'(1));

        // Streaming through the scoreboard: 1..8 back to back.
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid_i   = 1'b1;
            payload_i = PW'(i);
            exp_q.push_back(PW'(i));
            step();
            chk("stream_valid", 128'(valid_o), 128'(1));
            if (valid_o && exp_q.size() > 0) begin
                exp_pl = exp_q.pop_front();
                chk("stream_payload", 128'(payload_o), 128'(exp_pl));
            end
        end
        valid_i = 1'b0;
        step();
        chk("stream_drained", 128'(valid_o), 128'(0));
        chk("stream_queue_empty", 128'(exp_q.size()), 128'(0));
        chk("stream_stall", 128'(stallCycles_o), 128'(0));

        // Table-driven handshake / flush vectors.
        for (int v = 0; v < 8; v++) begin
            valid_i   = vecs[v].vi;
            ready_i   = vecs[v].ri;
            flush_i   = vecs[v].fl;
            payload_i = vecs[v].pl;
            #1;
            chk($sformatf("vec%0d_ready", v), 128'(ready_o), 128'(vecs[v].exp_ready));
            step();
            chk($sformatf("vec%0d_valid", v), 128'(valid_o), 128'(vecs[v].exp_valid));
            if (vecs[v].chk_pl) begin
                chk($sformatf("vec%0d_payload", v), 128'(payload_o), 128'(vecs[v].exp_pl));
            end
        end
        drive_idle();

        // Reset asserted mid-transfer clears state without waiting for an edge.
        ready_i   = 1'b0;
        valid_i   = 1'b1;
        payload_i = 96'h55;
        step();
        valid_i = 1'b0;
        step();
        chk("mid_valid_before", 128'(valid_o), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(valid_o), 128'(0));
        chk("mid_rst_stall", 128'(stallCycles_o), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("mid_rst_ready", 128'(ready_o), 128'(1));

        // Hold snoop on source 1; source 2 is unused and must ignore matches.
        valid_i     = 1'b1;
        payload_i   = 96'h77;
        src1Valid_i = 1'b1;
        src2Valid_i = 1'b0;
        phySrc1_i   = 7'h12;
        phySrc2_i   = 7'h34;
        src1Data_i  = 64'hAAAA;
        src2Data_i  = 64'hBBBB;
        bypass[0]   = '{1'b1, 7'h12, 64'h9999};
        step();
        chk("snoop_load_src1", 128'(src1Data_o), 128'(64'hAAAA));
        chk("snoop_load_src2", 128'(src2Data_o), 128'(64'hBBBB));
        drive_idle();
        bypass[1] = '{1'b1, 7'h12, 64'h1111};
        bypass[3] = '{1'b1, 7'h12, 64'h3333};
        bypass[2] = '{1'b1, 7'h34, 64'hDEAD};
        step();
        chk("snoop_high_lane", 128'(src1Data_o), 128'(64'h3333));
        chk("snoop_unused_src2", 128'(src2Data_o), 128'(64'hBBBB));
        clear_bypass();
        bypass[0] = '{1'b0, 7'h12, 64'h5555};
        step();
        chk("snoop_invalid_lane", 128'(src1Data_o), 128'(64'h3333));
        bypass[0] = '{1'b1, 7'h12, 64'h0777};
        step();
        chk("snoop_lane0", 128'(src1Data_o), 128'(64'h0777));
        chk("snoop_payload", 128'(payload_o), 128'(96'h77));
        chk("snoop_stall", 128'(stallCycles_o), 128'(3));
        clear_bypass();
        ready_i = 1'b1;
        step();
        chk("snoop_drain_valid", 128'(valid_o), 128'(0));
        chk("snoop_drain_stall", 128'(stallCycles_o), 128'(3));

        // Stall counter saturation at 4 bits.
        ready_i   = 1'b0;
        valid_i   = 1'b1;
        payload_i = 96'h99;
        step();
        valid_i = 1'b0;
        repeat (20) step();
        chk("sat_stall", 128'(stallCycles_o), 128'(15));
        chk("sat_valid", 128'(valid_o), 128'(1));
        ready_i = 1'b1;
        step();
        chk("sat_release_valid", 128'(valid_o), 128'(0));
        chk("sat_release_stall", 128'(stallCycles_o), 128'(15));
        step();
        chk("sat_idle_stall", 128'(stallCycles_o), 128'(15));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regread_exe_latch.md
Name: regread_exe_latch

Overview:
- Pipeline latch between the register-read/bypass stage and the execute stage, one per issue lane.
- Captures the issued payload plus two source operands, already resolved by the per-operand bypass muxes.
- While held by execute back-pressure, the latch keeps snooping the bypass network so held operands pick up newly produced values.
- Valid/ready handshake on both sides, flush on mispredict, and a saturating stall counter for performance monitoring.

Parameters:
- SIZE_PHYSICAL_LOG, 7, physical register tag width
- SIZE_DATA, 64, operand width
- ISSUE_WIDTH, 4, number of bypass packets snooped
- PAYLOAD_WIDTH, 96, opaque issue payload width (opcode, destination, ROB/LSQ ids)
- STALL_CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- flush_i  in  1  kill the held and incoming instruction
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  latch can accept this cycle
- payload_i  in  PAYLOAD_WIDTH  issue payload
- src1Valid_i  in  1  instruction reads source 1
- src2Valid_i  in  1  instruction reads source 2
- phySrc1_i  in  SIZE_PHYSICAL_LOG  source 1 tag
- phySrc2_i  in  SIZE_PHYSICAL_LOG  source 2 tag
- src1Data_i  in  SIZE_DATA  bypass-resolved source 1 value
- src2Data_i  in  SIZE_DATA  bypass-resolved source 2 value
- bypassPacket_i  in  bypassPkt[0:ISSUE_WIDTH-1]  {valid, tag, data} per lane
- valid_o  out  1  latch holds a live instruction
- ready_i  in  1  execute accepts this cycle
- payload_o  out  PAYLOAD_WIDTH  held payload
- src1Data_o  out  SIZE_DATA  held source 1 value
- src2Data_o  out  SIZE_DATA  held source 2 value
- stallCycles_o  out  STALL_CNT_WIDTH  saturating count of held-not-accepted cycles

Behaviour:
- Reset (reset == 0, asynchronous):
  - valid_o, payload_o, src*Data_o, stallCycles_o and the internal tags/src valids all clear to 0.
  - ready_o is 1 from the first cycle after deassertion.
- Handshake:
  - ready_o = !valid_o || ready_i. Purely combinational; never depends on valid_i.
  - load = valid_i && ready_o && !flush_i.
  - drain = valid_o && ready_i.
- Latency: one cycle, input to valid_o.
- Next-state valid:
  - flush_i: valid_o becomes 0. Flush has priority over load, hold and drain.
  - else load: valid_o becomes 1 and payload, tags, src valids and data are captured from the inputs.
  - else drain: valid_o becomes 0; data and payload are left unchanged (don't-care).
  - else hold: valid_o is unchanged.
- Simultaneous drain and load: the new instruction replaces the old in the same edge, so back-to-back throughput is 1 per cycle.
- Hold snoop (valid_o && !ready_i && !flush_i), for each source s:
  - Update only if srcsValid.
  - Scan bypass lanes 0..ISSUE_WIDTH-1; a lane matches if valid && tag == held phySrcs.
  - The highest-index matching lane wins and its data is written into srcsData.
  - No match: the value is held.
  - Priority order is identical to the register-read bypass mux.
- No snoop on the load cycle; incoming data is already bypass-resolved.
- Stall counter: increments by 1 on every hold cycle and saturates at all-ones. It is cleared only by reset; it is not cleared by flush.
- No combinational path from bypassPacket_i to any output.

Decomposition:
- Shared package:
  - bypassPkt struct {valid, tag[SIZE_PHYSICAL_LOG], data[SIZE_DATA]}, already owned by the register-read stage.
  - SIZE_PHYSICAL_LOG, SIZE_DATA and ISSUE_WIDTH constants.
- Sub-module operand_snoop, combinational, instantiated twice:
  - Inputs: tag, srcValid, held data, bypass packets.
  - Output: next data.

Test Plan:
- Reset: hold reset=0 mid-transfer with valid_o=1 → valid_o=0, stallCycles_o=0 immediately; ready_o=1 once reset=1.
- Streaming: valid_i=1, ready_i=1 for 8 cycles with payloads 1..8 → payload_o 1..8 appears on consecutive cycles with no bubbles; stallCycles_o=0.
- Hold snoop:
  - Stimulus: load phySrc1=0x12, src1Data=0xAAAA; ready_i=0; next cycle lanes 1 and 3 both carry valid tag 0x12 with data 0x1111 and 0x3333.
  - Response: src1Data_o=0x3333.
  - Stimulus: lane 0 then carries tag 0x12 with valid=0.
  - Response: value stays 0x3333.
- Unused source: src2Valid=0 with a bypass tag matching phySrc2 → src2Data_o is unchanged.
- Flush priority: valid_o=1, ready_i=0, flush_i=1 and valid_i=1 in the same cycle → next cycle valid_o=0 and the new payload is not captured.
- Counter saturation: STALL_CNT_WIDTH=4, hold for 20 cycles → stallCycles_o=15; then release ready_i → count stays at 15.
